text_write_scheduler: RTL and testbench

- Sole owner of the video memory write port: `write`, `xtextwrite`, `ytextwrite` and `value`.
- Shares that port between two requesters:
  - single-cell writes from the I2C slave, which come as strobes with no backpressure and are buffered in a small FIFO;
  - bulk fill commands (screen clear, row clear, clear-to-end-of-row) on a valid/ready handshake.
- Sits between `i2c_slave` / command decode and `video_memory`. It emits at most one cell write per `clk`.

---
 rtl/text_write_scheduler.sv | 239 +++++++++++++++++++++++
 tb/tb_text_write_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_write_scheduler.sv
// text_write_scheduler: owns the video memory write port and shares it
// between buffered single-cell writes (I2C strobes) and bulk fill commands.
// At most one cell write is issued per clk; all outputs except cmd_ready
// are registered.
module text_write_scheduler #(
  parameter int NCOLS      = 100,
  parameter int NROWS      = 37,
  parameter int COL_W      = 7,
  parameter int ROW_W      = 6,
  parameter int ATTR_W     = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_button,
  input  logic              wr_strobe,
  input  logic [COL_W-1:0]  wr_x,
  input  logic [ROW_W-1:0]  wr_y,
  input  logic [ATTR_W-1:0] wr_value,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [COL_W-1:0]  cmd_x,
  input  logic [ROW_W-1:0]  cmd_y,
  input  logic [ATTR_W-1:0] cmd_value,
  input  logic              ovf_clear,
  output logic              mem_write,
  output logic [COL_W-1:0]  mem_x,
  output logic [ROW_W-1:0]  mem_y,
  output logic [ATTR_W-1:0] mem_value,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = COL_W + ROW_W + ATTR_W;

  localparam logic [COL_W-1:0] X_LAST = COL_W'(NCOLS - 1);
  localparam logic [ROW_W-1:0] Y_LAST = ROW_W'(NROWS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_FILL = 1'b1;

  localparam logic [1:0] OP_SCREEN = 2'b00;
  localparam logic [1:0] OP_ROW    = 2'b01;
  localparam logic [1:0] OP_EOL    = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  // Single-write FIFO: storage plus wrap-bit pointers
  logic [EW-1:0]    fifo_mem [FIFO_DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             fifo_empty, fifo_full;
  logic             push, pop, ovf_set;
  logic [EW-1:0]    fifo_head;
  logic [COL_W-1:0] head_x;
  logic [ROW_W-1:0] head_y;
  logic [ATTR_W-1:0] head_v;

  // Fill walker state
  logic [0:0]        state_q, state_d;
  logic [COL_W-1:0]  cx_q, cx_d;
  logic [ROW_W-1:0]  cy_q, cy_d;
  logic [COL_W-1:0]  xs_q, xs_d;
  logic [ROW_W-1:0]  ye_q, ye_d;
  logic [ATTR_W-1:0] fval_q, fval_d;
  logic              last_q, last_d;

  // Registered outputs
  logic              mem_write_q, mem_write_d;
  logic [COL_W-1:0]  mem_x_q, mem_x_d;
  logic [ROW_W-1:0]  mem_y_q, mem_y_d;
  logic [ATTR_W-1:0] mem_value_q, mem_value_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;

  // Command decode
  logic              accept;
  logic              cmd_bad;
  logic [COL_W-1:0]  cmd_xs;
  logic [ROW_W-1:0]  cmd_ys;
  logic [ROW_W-1:0]  cmd_ye;

  // FIFO status, push/pop decisions and overflow tracking
  always_comb begin
    fifo_empty = (wptr_q == rptr_q);
    fifo_full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    fifo_head  = fifo_mem[rptr_q[AW-1:0]];
    head_x     = fifo_head[EW-1 -: COL_W];
    head_y     = fifo_head[ATTR_W +: ROW_W];
    head_v     = fifo_head[ATTR_W-1:0];

    pop        = (state_q == ST_IDLE) && !fifo_empty;
    cmd_ready  = (state_q == ST_IDLE) && fifo_empty;
    // A same-cycle pop frees the slot, so a full FIFO can still take the strobe
    push       = wr_strobe && (!fifo_full || pop);
    ovf_set    = wr_strobe && fifo_full && !pop;

    wptr_d     = push ? wptr_q + (AW+1)'(1) : wptr_q;
    rptr_d     = pop  ? rptr_q + (AW+1)'(1) : rptr_q;
    overflow_d = ovf_set | (overflow_q & ~ovf_clear);
  end

  // Bulk command decode: bounds and rejection of unusable commands
  always_comb begin
    accept  = cmd_valid && cmd_ready;
    cmd_bad = (cmd_op == OP_RSVD) ||
              ((cmd_op != OP_SCREEN) && (cmd_y > Y_LAST)) ||
              ((cmd_op == OP_EOL) && (cmd_x > X_LAST));
    cmd_xs  = (cmd_op == OP_EOL)    ? cmd_x : '0;
    cmd_ys  = (cmd_op == OP_SCREEN) ? '0    : cmd_y;
    cmd_ye  = (cmd_op == OP_SCREEN) ? Y_LAST : cmd_y;
  end

  // Scheduler: FIFO entries first, then bulk commands, then the fill walk.
  // The first fill cell is issued on the accepting edge so writes start one
  // cycle after acceptance; last_q marks that the final cell has gone out,
  // and the following FILL cycle only raises done.
  always_comb begin
    state_d     = state_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    xs_d        = xs_q;
    ye_d        = ye_q;
    fval_d      = fval_q;
    last_d      = last_q;
    mem_write_d = 1'b0;
    mem_x_d     = mem_x_q;
    mem_y_d     = mem_y_q;
    mem_value_d = mem_value_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          if ((head_x <= X_LAST) && (head_y <= Y_LAST)) begin
            mem_write_d = 1'b1;
            mem_x_d     = head_x;
            mem_y_d     = head_y;
            mem_value_d = head_v;
          end
        end else if (accept) begin
          if (cmd_bad) begin
            done_d = 1'b1;
          end else begin
            mem_write_d = 1'b1;
            mem_x_d     = cmd_xs;
            mem_y_d     = cmd_ys;
            mem_value_d = cmd_value;
            xs_d        = cmd_xs;
            ye_d        = cmd_ye;
            fval_d      = cmd_value;
            last_d      = (cmd_xs == X_LAST) && (cmd_ys == cmd_ye);
            if (cmd_xs == X_LAST) begin
              cx_d = cmd_xs;
              cy_d = cmd_ys + ROW_W'(1);
            end else begin
              cx_d = cmd_xs + COL_W'(1);
              cy_d = cmd_ys;
            end
            state_d = ST_FILL;
          end
        end
      end
      ST_FILL: begin
        if (last_q) begin
          done_d  = 1'b1;
          last_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          mem_write_d = 1'b1;
          mem_x_d     = cx_q;
          mem_y_d     = cy_q;
          mem_value_d = fval_q;
          last_d      = (cx_q == X_LAST) && (cy_q == ye_q);
          if (cx_q == X_LAST) begin
            cx_d = xs_q;
            cy_d = cy_q + ROW_W'(1);
          end else begin
            cx_d = cx_q + COL_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO storage; emptiness is governed by the pointers, so no reset here
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q[AW-1:0]] <= {wr_x, wr_y, wr_value};
  end

  // State, pointers and output registers
  always_ff @(posedge clk or negedge reset_button) begin
    if (!reset_button) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      xs_q        <= '0;
      ye_q        <= '0;
      fval_q      <= '0;
      last_q      <= 1'b0;
      mem_write_q <= 1'b0;
      mem_x_q     <= '0;
      mem_y_q     <= '0;
      mem_value_q <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      xs_q        <= xs_d;
      ye_q        <= ye_d;
      fval_q      <= fval_d;
      last_q      <= last_d;
      mem_write_q <= mem_write_d;
      mem_x_q     <= mem_x_d;
      mem_y_q     <= mem_y_d;
      mem_value_q <= mem_value_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
    end
  end

  assign mem_write = mem_write_q;
  assign mem_x     = mem_x_q;
  assign mem_y     = mem_y_q;
  assign mem_value = mem_value_q;
  assign busy      = (state_q == ST_FILL);
  assign done      = done_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_text_write_scheduler.sv
// Testbench for text_write_scheduler: directed scenarios plus a randomized
// phase, all compared against a queue-based reference model.
module tb_text_write_scheduler;

  localparam int NCOLS = 100;
  localparam int NROWS = 37;

  logic        clk = 1'b0;
  logic        reset_button = 1'b0;
  logic        wr_strobe = 1'b0;
  logic [6:0]  wr_x = '0;
  logic [5:0]  wr_y = '0;
  logic [23:0] wr_value = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [6:0]  cmd_x = '0;
  logic [5:0]  cmd_y = '0;
  logic [23:0] cmd_value = '0;
  logic        ovf_clear = 1'b0;
  logic        mem_write;
  logic [6:0]  mem_x;
  logic [5:0]  mem_y;
  logic [23:0] mem_value;
  logic        busy;
  logic        done;
  logic        overflow;

  always #5 clk = ~clk;

  text_write_scheduler #(
    .NCOLS(NCOLS), .NROWS(NROWS), .COL_W(7), .ROW_W(6),
    .ATTR_W(24), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset_button(reset_button),
    .wr_strobe(wr_strobe), .wr_x(wr_x), .wr_y(wr_y), .wr_value(wr_value),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_value(cmd_value),
    .ovf_clear(ovf_clear),
    .mem_write(mem_write), .mem_x(mem_x), .mem_y(mem_y), .mem_value(mem_value),
    .busy(busy), .done(done), .overflow(overflow)
  );

  typedef struct packed {
    logic [6:0]  x;
    logic [5:0]  y;
    logic [23:0] v;
  } cell_t;

  // Reference model: pending strobes, remaining fill cells, expected outputs
  cell_t       fifo_m[$];
  cell_t       pend[$];
  bit          m_busy;
  logic        e_write, e_done, e_ovf;
  logic [6:0]  e_x;
  logic [5:0]  e_y;
  logic [23:0] e_v;

  int errors = 0;
  int checks = 0;
  int wcnt = 0;
  int dcnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return !m_busy && (fifo_m.size() == 0);
  endfunction

  task automatic model_reset();
    fifo_m.delete();
    pend.delete();
    m_busy  = 1'b0;
    e_write = 1'b0; e_done = 1'b0; e_ovf = 1'b0;
    e_x = '0; e_y = '0; e_v = '0;
  endtask

  task automatic emit(input cell_t c);
    e_write = 1'b1; e_x = c.x; e_y = c.y; e_v = c.v;
  endtask

  // Every cell a command covers, in row-major order
  task automatic build_cells(input logic [1:0] op, input logic [6:0] x0,
                             input logic [5:0] y0, input logic [23:0] v);
    cell_t c;
    pend.delete();
    c.v = v;
    case (op)
      2'd0: for (int y = 0; y < NROWS; y++)
              for (int x = 0; x < NCOLS; x++) begin
                c.x = 7'(x); c.y = 6'(y); pend.push_back(c);
              end
      2'd1: if (int'(y0) < NROWS)
              for (int x = 0; x < NCOLS; x++) begin
                c.x = 7'(x); c.y = y0; pend.push_back(c);
              end
      2'd2: if (int'(y0) < NROWS && int'(x0) < NCOLS)
              for (int x = int'(x0); x < NCOLS; x++) begin
                c.x = 7'(x); c.y = y0; pend.push_back(c);
              end
      default: ;
    endcase
  endtask

  // Advance the model across one rising edge using the current inputs
  task automatic model_step();
    bit full, pop, ovf_set;
    cell_t c;
    if (!reset_button) begin
      model_reset();
      return;
    end
    full    = (fifo_m.size() == 4);
    pop     = !m_busy && (fifo_m.size() > 0);
    ovf_set = 1'b0;
    e_write = 1'b0;
    e_done  = 1'b0;
    if (m_busy) begin
      if (pend.size() > 0) emit(pend.pop_front());
      else begin e_done = 1'b1; m_busy = 1'b0; end
    end else if (pop) begin
      c = fifo_m.pop_front();
      if (int'(c.x) < NCOLS && int'(c.y) < NROWS) emit(c);
    end else if (cmd_valid) begin
      build_cells(cmd_op, cmd_x, cmd_y, cmd_value);
      if (pend.size() == 0) e_done = 1'b1;
      else begin emit(pend.pop_front()); m_busy = 1'b1; end
    end
    if (wr_strobe) begin
      if (!full || pop) begin
        c.x = wr_x; c.y = wr_y; c.v = wr_value;
        fifo_m.push_back(c);
      end else ovf_set = 1'b1;
    end
    e_ovf = ovf_set | (e_ovf & !ovf_clear);
  endtask

  // One clock: check outputs mid-cycle, step model, drop one-shot inputs
  task automatic tick();
    bit acc;
    @(negedge clk);
    check("mem_write", 32'(mem_write), 32'(e_write));
    check("mem_x",     32'(mem_x),     32'(e_x));
    check("mem_y",     32'(mem_y),     32'(e_y));
    check("mem_value", 32'(mem_value), 32'(e_v));
    check("busy",      32'(busy),      32'(m_busy));
    check("done",      32'(done),      32'(e_done));
    check("overflow",  32'(overflow),  32'(e_ovf));
    check("cmd_ready", 32'(cmd_ready), 32'(m_ready()));
    if (mem_write) wcnt++;
    if (done) dcnt++;
    acc = cmd_valid && m_ready();
    model_step();
    @(posedge clk);
    #1;
    wr_strobe = 1'b0;
    ovf_clear = 1'b0;
    if (acc) cmd_valid = 1'b0;
  endtask

  task automatic strobe(input int x, input int y, input logic [23:0] v);
    wr_x = 7'(x); wr_y = 6'(y); wr_value = v; wr_strobe = 1'b1;
  endtask

  task automatic command(input logic [1:0] op, input int x, input int y,
                         input logic [23:0] v);
    cmd_op = op; cmd_x = 7'(x); cmd_y = 6'(y); cmd_value = v; cmd_valid = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    reset_button = 1'b1;
    tick();

    // Single write, two-cycle latency
    wcnt = 0;
    strobe(5, 3, 24'h000041);
    tick();
    repeat (5) tick();
    check("single_writes", 32'(wcnt), 32'd1);
    check("single_ovf", 32'(overflow), 32'd0);

    // Full screen clear
    wcnt = 0; dcnt = 0;
    command(2'd0, 0, 0, 24'h000020);
    tick();
    repeat (3705) tick();
    check("screen_writes", 32'(wcnt), 32'd3700);
    check("screen_done", 32'(dcnt), 32'd1);

    // Clear to end of row near the right edge
    wcnt = 0; dcnt = 0;
    command(2'd2, 97, 10, 24'h000055);
    tick();
    repeat (6) tick();
    check("eol_writes", 32'(wcnt), 32'd3);
    check("eol_done", 32'(dcnt), 32'd1);

    // Row clear on a row past the screen
    wcnt = 0; dcnt = 0;
    command(2'd1, 0, 40, 24'h000066);
    tick();
    repeat (4) tick();
    check("badrow_writes", 32'(wcnt), 32'd0);
    check("badrow_done", 32'(dcnt), 32'd1);

    // Strobes during a fill: four kept, two lost
    wcnt = 0;
    command(2'd0, 0, 0, 24'h000700);
    tick();
    for (int i = 0; i < 6; i++) begin
      strobe(i * 10, i, 24'h000100 + 24'(i));
      tick();
    end
    repeat (3710) tick();
    check("ovf_after_fill", 32'(overflow), 32'd1);
    check("fill_plus_strobes", 32'(wcnt), 32'd3704);
    ovf_clear = 1'b1;
    tick();
    tick();
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Out-of-range strobe is discarded silently
    wcnt = 0;
    strobe(120, 2, 24'h000077);
    tick();
    repeat (4) tick();
    check("oob_writes", 32'(wcnt), 32'd0);
    check("oob_ovf", 32'(overflow), 32'd0);

    // Command held while strobes are pending
    wcnt = 0;
    strobe(1, 1, 24'h000011); tick();
    strobe(2, 1, 24'h000012); tick();
    strobe(3, 1, 24'h000013);
    command(2'd2, 98, 2, 24'h000099);
    tick();
    repeat (8) tick();
    check("held_cmd_writes", 32'(wcnt), 32'd5);

    // Reset in the middle of a fill
    command(2'd0, 0, 0, 24'h000033);
    tick();
    for (int i = 0; i < 6; i++) begin
      strobe(50, 20, 24'h000200 + 24'(i));
      tick();
    end
    repeat (493) tick();
    reset_button = 1'b0;
    #1;
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    model_reset();
    repeat (2) tick();
    reset_button = 1'b1;
    wcnt = 0;
    repeat (20) tick();
    check("post_rst_writes", 32'(wcnt), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 7) == 0)
          strobe(int'($urandom_range(100, 127)), int'($urandom_range(0, 36)), 24'($urandom));
        else
          strobe(int'($urandom_range(0, 99)), int'($urandom_range(0, 40)), 24'($urandom));
      end
      if ($urandom_range(0, 15) == 0) ovf_clear = 1'b1;
      if (!cmd_valid && $urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 2))
          0: command(2'd1, int'($urandom_range(0, 99)), int'($urandom_range(0, 40)), 24'($urandom));
          1: command(2'd2, int'($urandom_range(85, 110)), int'($urandom_range(0, 40)), 24'($urandom));
          default: command(2'd3, 0, 0, 24'($urandom));
        endcase
      end
      tick();
    end
    repeat (300) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
